seq_checker: RTL
================

Name: seq_checker

Overview:
- Synthesizable run-time checker for counter-style programs running on the CPU, e.g. the multi-byte register counter loop.
- Samples a WIDTH-bit observed value on each strobe and checks it against the expected next value: previous +STEP (up mode) or previous −STEP (down mode), modulo 2^WIDTH.
- Reports per-sample ok/error/wrap pulses, sample and error counts, and a sticky FAIL state.
- Sits beside the CPU in top-level benches and on the FPGA build; the strobe is typically driven from a MAR/port write enable.

Parameters:
- WIDTH, 16, observed value width in bits (1..32).
- STEP, 1, increment/decrement per sample, taken modulo 2^WIDTH.
- INIT_VALUE, 0, required first value when CHECK_INIT=1.
- CHECK_INIT, 1, 1 = first sample must equal INIT_VALUE; 0 = first sample is accepted as the seed.
- MAX_ERRORS, 1, error count that forces FAIL; 0 = never enter FAIL.
- CNT_W, 32, width of sample_count and err_count.

Ports:
- clk  in  1  system clock, rising edge active.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous restart to IDLE; counts are zeroed.
- sample_en  in  1  one sample taken per cycle while high.
- value  in  WIDTH  observed value; valid while sample_en is high.
- mode_down  in  1  0 = expect +STEP, 1 = expect −STEP; sampled with each sample.
- ok_pulse  out  1  one-cycle pulse: last sample matched.
- err_pulse  out  1  one-cycle pulse: last sample mismatched.
- wrap_pulse  out  1  one-cycle pulse: matched sample crossed the modulus (up: prev > value; down: prev < value).
- expected  out  WIDTH  value required for the next sample.
- last_value  out  WIDTH  most recent sampled value.
- sample_count  out  CNT_W  samples taken since reset/clear; saturates at all-ones.
- err_count  out  CNT_W  mismatches since reset/clear; saturates.
- state  out  2  00 IDLE, 01 RUN, 10 FAIL.

Behaviour:
- Reset (async, immediate): state=IDLE; all pulses 0; counts 0; last_value=0; expected=INIT_VALUE.
- All outputs are registered. The result of a sample is visible on the cycle after sample_en (latency 1). Pulses last exactly one cycle.
- IDLE + sample_en:
  - CHECK_INIT=1 and value≠INIT_VALUE: err_pulse, err_count++, then go to RUN.
  - Otherwise: ok_pulse, then go to RUN.
  - In all cases: last_value=value; expected=value±STEP (per mode_down); sample_count++.
- RUN + sample_en:
  - value==expected: ok_pulse; wrap_pulse if the modulus was crossed.
  - Mismatch: err_pulse, err_count++. expected is not moved off the old sequence (see the optional feature).
  - On match: expected=value±STEP. last_value is always updated; sample_count++.
- Enter FAIL when the incremented err_count equals MAX_ERRORS (MAX_ERRORS≠0). This happens on the same clock as the error update, so state reads FAIL together with err_pulse.
- FAIL is sticky:
  - Samples still increment sample_count and update last_value.
  - No ok/err/wrap pulses; expected and err_count are frozen.
  - Only reset or clear leave FAIL.
- clear has priority over sample_en in the same cycle: the sample is discarded and state goes to IDLE with reset values.
- Arithmetic is modulo 2^WIDTH. With WIDTH=16, STEP=1 in up mode, 16'hFFFF → 16'h0000 is a match with wrap_pulse.
- mode_down may change between samples. The expectation for the next sample always uses the mode sampled with the current sample.
- sample_en low: no state, count or pulse change.

Optional Feature:
- Macro: SEQ_CHECKER_RESYNC_EN.
- Defined: on a mismatch in RUN, expected resyncs to value±STEP, so a single glitch costs exactly one error.
- Undefined: on a mismatch, expected holds its previous value. The checker keeps demanding the original sequence, and every later sample errors until the sequence realigns.

Test Plan:
- Reset; samples 0,1,2,3 (up, WIDTH=16) → four ok_pulses, err_count=0, expected=4, sample_count=4, state=RUN.
- Seed 16'hFFFE via IDLE with CHECK_INIT=0, then samples FFFF, 0000 → ok on both, wrap_pulse only on 0000, expected=0001.
- Samples 0,1,5 with MAX_ERRORS=1 → err_pulse on 5, state=FAIL the same cycle; further sample 6 produces no pulses, sample_count=4, err_count=1.
- MAX_ERRORS=0, samples 0,1,5,6 → errors on 5 and 6 (err_count=2) without the macro; with SEQ_CHECKER_RESYNC_EN only 5 errors (err_count=1) and 6 is ok.
- mode_down=1, STEP=2, CHECK_INIT=0, seed 0001 then 16'hFFFF → ok with wrap_pulse, expected=16'hFFFD.
- Assert reset mid-run, and separately clear together with sample_en in RUN → state=IDLE, counts 0, no pulse, sampled value ignored.

Source files
------------

// File: rtl/seq_checker_if.sv
// seq_checker_if: sample/control inputs and result outputs of seq_checker.
// master = sampling side (CPU harness or bench), slave = the checker.
interface seq_checker_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32
);
    logic             clear;
    logic             sample_en;
    logic [WIDTH-1:0] value;
    logic             mode_down;
    logic             ok_pulse;
    logic             err_pulse;
    logic             wrap_pulse;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] last_value;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] err_count;
    logic [1:0]       state;

    modport master (
        output clear, sample_en, value, mode_down,
        input  ok_pulse, err_pulse, wrap_pulse, expected, last_value,
               sample_count, err_count, state
    );

    modport slave (
        input  clear, sample_en, value, mode_down,
        output ok_pulse, err_pulse, wrap_pulse, expected, last_value,
               sample_count, err_count, state
    );
endinterface

// File: rtl/seq_checker.sv
// seq_checker: run-time checker for counter-style value sequences.
// Each strobed sample must equal the previous value +/- STEP (mod 2^WIDTH).
// Reports ok/err/wrap pulses, saturating sample/error counts and a sticky
// FAIL state. All outputs are registered (result visible one cycle later).
// Optional feature: define SEQ_CHECKER_RESYNC_EN to resync the expectation
// on a mismatch instead of holding the original sequence.
module seq_checker #(
    parameter int WIDTH      = 16,
    parameter int STEP       = 1,
    parameter int INIT_VALUE = 0,
    parameter int CHECK_INIT = 1,
    parameter int MAX_ERRORS = 1,
    parameter int CNT_W      = 32
) (
    input logic          clk,
    input logic          reset,
    seq_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FAIL = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] INIT_W    = WIDTH'(INIT_VALUE);
    localparam logic [CNT_W-1:0] MAX_ERR_W = CNT_W'(MAX_ERRORS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               FAIL_EN   = (MAX_ERRORS != 0);
    localparam bit               INIT_CHK  = (CHECK_INIT != 0);

    state_t           state_q, state_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic             exp_down_q, exp_down_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;
    logic [CNT_W-1:0] scnt_inc, ecnt_inc;

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v,
                                                 input logic down);
        return down ? (v - STEP_W) : (v + STEP_W);
    endfunction

    // Register bank: FSM state plus every registered output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            wrap_q     <= 1'b0;
            expected_q <= INIT_W;
            exp_down_q <= 1'b0;
            last_q     <= '0;
            scnt_q     <= '0;
            ecnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
            expected_q <= expected_d;
            exp_down_q <= exp_down_d;
            last_q     <= last_d;
            scnt_q     <= scnt_d;
            ecnt_q     <= ecnt_d;
        end
    end

    // Next-state and next-output logic; clear outranks sample_en.
    always_comb begin
        state_d    = state_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        wrap_d     = 1'b0;
        expected_d = expected_q;
        exp_down_d = exp_down_q;
        last_d     = last_q;
        scnt_d     = scnt_q;
        ecnt_d     = ecnt_q;
        scnt_inc   = (scnt_q == '1) ? scnt_q : scnt_q + CNT_ONE;
        ecnt_inc   = (ecnt_q == '1) ? ecnt_q : ecnt_q + CNT_ONE;

        if (bus.clear) begin
            state_d    = IDLE;
            expected_d = INIT_W;
            exp_down_d = 1'b0;
            last_d     = '0;
            scnt_d     = '0;
            ecnt_d     = '0;
        end else if (bus.sample_en) begin
            last_d = bus.value;
            scnt_d = scnt_inc;
            case (state_q)
                IDLE: begin
                    expected_d = advance(bus.value, bus.mode_down);
                    exp_down_d = bus.mode_down;
                    state_d    = RUN;
                    if (INIT_CHK && (bus.value != INIT_W)) begin
                        err_d  = 1'b1;
                        ecnt_d = ecnt_inc;
                        if (FAIL_EN && (ecnt_inc == MAX_ERR_W)) state_d = FAIL;
                    end else begin
                        ok_d = 1'b1;
                    end
                end
                RUN: begin
                    if (bus.value == expected_q) begin
                        ok_d       = 1'b1;
                        // Crossing judged in the direction that produced expected_q.
                        wrap_d     = exp_down_q ? (last_q < bus.value)
                                                : (last_q > bus.value);
                        expected_d = advance(bus.value, bus.mode_down);
                        exp_down_d = bus.mode_down;
                    end else begin
                        err_d  = 1'b1;
                        ecnt_d = ecnt_inc;
`ifdef SEQ_CHECKER_RESYNC_EN
                        expected_d = advance(bus.value, bus.mode_down);
                        exp_down_d = bus.mode_down;
`endif
                        if (FAIL_EN && (ecnt_inc == MAX_ERR_W)) state_d = FAIL;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.ok_pulse     = ok_q;
    assign bus.err_pulse    = err_q;
    assign bus.wrap_pulse   = wrap_q;
    assign bus.expected     = expected_q;
    assign bus.last_value   = last_q;
    assign bus.sample_count = scnt_q;
    assign bus.err_count    = ecnt_q;
    assign bus.state        = state_q;

endmodule
